// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg -- shared definitions for the dispatch controller.
// Holds the renamed-op width, the position and encoding of the op class
// field, the dispatch FSM state encoding and a class decode helper.
// No ports (package).

`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 48
`endif

package dispatch_ctrl_pkg;

    localparam int unsigned OpSz     = `RENAMED_OP_SZ;
    localparam int unsigned ClassLsb = 44;
    localparam int unsigned ClassW   = 3;

    localparam logic [ClassW-1:0] TermCode = 3'b111;

    typedef enum logic [1:0] {
        OpAlu,
        OpMem,
        OpTerm
    } op_class_e;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StIdle  = 2'd2
    } state_e;

    // 3'b111 is TERM; any other code with the top bit set is MEM; 3'b0xx is ALU.
    function automatic op_class_e op_class(input logic [ClassW-1:0] code);
        if (code == TermCode) begin
            return OpTerm;
        end else if (code[2]) begin
            return OpMem;
        end
        return OpAlu;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// dispatch_ctrl_if -- decoded-op handshake between the decode stage and
// the dispatch controller.
//   instr_in    : FETCH_WIDTH packed renamed ops (slot g at g*OpSz)
//   instr_valid : per-slot valid
//   instr_used  : per-slot accept (consumed when valid & used)
//   alu_sel, mem_sel, term_sel : accepted slots routed per unit
// Modports: master = op producer, slave = dispatch controller.

interface dispatch_ctrl_if #(
    parameter int unsigned FETCH_WIDTH = 4
);
    import dispatch_ctrl_pkg::*;

    logic [OpSz*FETCH_WIDTH-1:0] instr_in;
    logic [FETCH_WIDTH-1:0]      instr_valid;
    logic [FETCH_WIDTH-1:0]      instr_used;
    logic [FETCH_WIDTH-1:0]      alu_sel;
    logic [FETCH_WIDTH-1:0]      mem_sel;
    logic [FETCH_WIDTH-1:0]      term_sel;

    modport master (
        output instr_in,
        output instr_valid,
        input  instr_used,
        input  alu_sel,
        input  mem_sel,
        input  term_sel
    );

    modport slave (
        input  instr_in,
        input  instr_valid,
        output instr_used,
        output alu_sel,
        output mem_sel,
        output term_sel
    );

endinterface

// File: rtl/dispatch_select.sv
// dispatch_select -- combinational in-order prefix / credit selection.
// Ports:
//   instr, valid       : packed ops and per-slot valid
//   enable             : high only while the controller may accept (RUN, out of reset)
//   alu_cred, mem_cred : credits currently available per queue
//   used               : accepted prefix
//   alu_sel, mem_sel, term_sel : used split by class
//   alu_acc, mem_acc   : number of ALU / MEM ops accepted this cycle
//   term_acc           : a TERM was accepted this cycle

module dispatch_select
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned ALU_DEPTH   = 8,
    parameter int unsigned MEM_DEPTH   = 4
) (
    input  logic [OpSz*FETCH_WIDTH-1:0]       instr,
    input  logic [FETCH_WIDTH-1:0]            valid,
    input  logic                              enable,
    input  logic [$clog2(ALU_DEPTH+1)-1:0]    alu_cred,
    input  logic [$clog2(MEM_DEPTH+1)-1:0]    mem_cred,
    output logic [FETCH_WIDTH-1:0]            used,
    output logic [FETCH_WIDTH-1:0]            alu_sel,
    output logic [FETCH_WIDTH-1:0]            mem_sel,
    output logic [FETCH_WIDTH-1:0]            term_sel,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]  alu_acc,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]  mem_acc,
    output logic                              term_acc
);

    localparam int unsigned CntW = $clog2(FETCH_WIDTH+1);

    int unsigned alu_n;
    int unsigned mem_n;
    logic        blocked;
    op_class_e   cls;

    // Only the class field of each op is inspected here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr;

    always_comb begin
        used     = '0;
        alu_sel  = '0;
        mem_sel  = '0;
        term_sel = '0;
        alu_n    = 0;
        mem_n    = 0;
        blocked  = 1'b0;
        cls      = OpAlu;
        for (int g = 0; g < FETCH_WIDTH; g++) begin
            cls = op_class(instr[g*OpSz + ClassLsb +: ClassW]);
            if (enable && valid[g] && !blocked) begin
                case (cls)
                    OpTerm: begin
                        used[g]     = 1'b1;
                        term_sel[g] = 1'b1;
                    end
                    OpMem: begin
                        if (mem_n < 32'(mem_cred)) begin
                            used[g]    = 1'b1;
                            mem_sel[g] = 1'b1;
                            mem_n      = mem_n + 1;
                        end
                    end
                    default: begin
                        if (alu_n < 32'(alu_cred)) begin
                            used[g]    = 1'b1;
                            alu_sel[g] = 1'b1;
                            alu_n      = alu_n + 1;
                        end
                    end
                endcase
            end
            // A refused slot ends the prefix; an accepted TERM ends it too.
            if (!used[g] || term_sel[g]) begin
                blocked = 1'b1;
            end
        end
    end

    assign alu_acc  = CntW'(alu_n);
    assign mem_acc  = CntW'(mem_n);
    assign term_acc = |term_sel;

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl -- dispatches decoded ops to ALU / MEM queues under credit
// flow control, with a RUN -> DRAIN -> IDLE termination sequence.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   wakeup       : restart request while IDLE
//   bus          : op handshake (dispatch_ctrl_if.slave)
//   alu_free, mem_free : queue entries released this cycle
//   running      : high in RUN
//   term_done    : one-cycle pulse in the cycle after DRAIN -> IDLE
//   stall_cycles : RUN cycles with slot 0 valid but not used (saturating)
// Config macro DISPATCH_CTRL_STATS_EN enables the stall counter; when
// undefined stall_cycles is tied to 0.

module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned ALU_DEPTH   = 8,
    parameter int unsigned MEM_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wakeup,
    dispatch_ctrl_if.slave                    bus,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]  alu_free,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]  mem_free,
    output logic                              running,
    output logic                              term_done,
    output logic [15:0]                       stall_cycles
);

    localparam int unsigned AluCw = $clog2(ALU_DEPTH+1);
    localparam int unsigned MemCw = $clog2(MEM_DEPTH+1);
    localparam int unsigned CntW  = $clog2(FETCH_WIDTH+1);

    state_e             state_q, state_d;
    logic [AluCw-1:0]   alu_cred_q, alu_cred_d;
    logic [MemCw-1:0]   mem_cred_q, mem_cred_d;
    logic               term_done_q;

    logic               accept_en;
    logic [CntW-1:0]    alu_acc, mem_acc;
    logic               term_acc;
    logic [31:0]        alu_sum, mem_sum;

    // Gating with rst keeps the handshake quiet during reset even though
    // the state register only clears at the next edge.
    assign accept_en = (state_q == StRun) && rst;

    dispatch_select #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .ALU_DEPTH   (ALU_DEPTH),
        .MEM_DEPTH   (MEM_DEPTH)
    ) u_select (
        .instr    (bus.instr_in),
        .valid    (bus.instr_valid),
        .enable   (accept_en),
        .alu_cred (alu_cred_q),
        .mem_cred (mem_cred_q),
        .used     (bus.instr_used),
        .alu_sel  (bus.alu_sel),
        .mem_sel  (bus.mem_sel),
        .term_sel (bus.term_sel),
        .alu_acc  (alu_acc),
        .mem_acc  (mem_acc),
        .term_acc (term_acc)
    );

    // Accepts never exceed the current credit, so the sums cannot underflow.
    always_comb begin
        alu_sum    = 32'(alu_cred_q) + 32'(alu_free) - 32'(alu_acc);
        mem_sum    = 32'(mem_cred_q) + 32'(mem_free) - 32'(mem_acc);
        alu_cred_d = (alu_sum > ALU_DEPTH) ? AluCw'(ALU_DEPTH) : AluCw'(alu_sum);
        mem_cred_d = (mem_sum > MEM_DEPTH) ? MemCw'(MEM_DEPTH) : MemCw'(mem_sum);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (term_acc) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if ((32'(alu_cred_d) == ALU_DEPTH) && (32'(mem_cred_d) == MEM_DEPTH)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (wakeup) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            alu_cred_q  <= AluCw'(ALU_DEPTH);
            mem_cred_q  <= MemCw'(MEM_DEPTH);
            term_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_cred_q  <= alu_cred_d;
            mem_cred_q  <= mem_cred_d;
            term_done_q <= (state_q == StDrain) && (state_d == StIdle);
        end
    end

    assign running   = (state_q == StRun);
    assign term_done = term_done_q;

`ifdef DISPATCH_CTRL_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((state_q == StRun) && bus.instr_valid[0] && !bus.instr_used[0]
                     && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl -- directed self-checking bench for dispatch_ctrl.

module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    localparam logic [2:0] A  = 3'b000;
    localparam logic [2:0] A2 = 3'b011;
    localparam logic [2:0] M  = 3'b100;
    localparam logic [2:0] M2 = 3'b110;
    localparam logic [2:0] T  = 3'b111;

    logic        clk;
    logic        rst;
    logic        wakeup;
    logic [2:0]  alu_free;
    logic [2:0]  mem_free;
    logic        running;
    logic        term_done;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    dispatch_ctrl_if #(.FETCH_WIDTH(4)) bus ();

    dispatch_ctrl #(
        .FETCH_WIDTH (4),
        .ALU_DEPTH   (8),
        .MEM_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wakeup       (wakeup),
        .bus          (bus.slave),
        .alu_free     (alu_free),
        .mem_free     (mem_free),
        .running      (running),
        .term_done    (term_done),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [`RENAMED_OP_SZ-1:0] op(input logic [2:0] c);
        logic [`RENAMED_OP_SZ-1:0] o;
        o = '1;
        o[ClassLsb +: ClassW] = c;
        return o;
    endfunction

    task automatic set_slots(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                             input logic [2:0] c3, input logic [3:0] v);
        bus.instr_in    = {op(c3), op(c2), op(c1), op(c0)};
        bus.instr_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_stall;

    initial begin
`ifdef DISPATCH_CTRL_STATS_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        rst      = 1'b0;
        wakeup   = 1'b0;
        alu_free = '0;
        mem_free = '0;
        set_slots(A, A, A, A, 4'b1111);
        #2;
        check("rst_used", 32'(bus.instr_used), 32'h0);
        check("rst_alu_sel", 32'(bus.alu_sel), 32'h0);
        tick();
        tick();
        check("rst_running", 32'(running), 32'h1);
        check("rst_alu_cred", 32'(dut.alu_cred_q), 32'd8);
        check("rst_mem_cred", 32'(dut.mem_cred_q), 32'd4);
        check("rst_term_done", 32'(term_done), 32'h0);
        check("rst_stall", 32'(stall_cycles), 32'h0);

        // Four ALU ops with full credit.
        rst = 1'b1;
        #1;
        check("alu4_used", 32'(bus.instr_used), 32'hF);
        check("alu4_alu_sel", 32'(bus.alu_sel), 32'hF);
        check("alu4_mem_sel", 32'(bus.mem_sel), 32'h0);
        tick();
        check("alu4_cred", 32'(dut.alu_cred_q), 32'd4);

        // Two valid ALU slots only.
        set_slots(A2, A, M, M, 4'b0011);
        #1;
        check("alu2_used", 32'(bus.instr_used), 32'h3);
        tick();
        check("alu2_cred", 32'(dut.alu_cred_q), 32'd2);

        // Credit 2: third ALU refused, MEM in slot 3 blocked by prefix.
        set_slots(A, A2, A, M, 4'b1111);
        #1;
        check("prefix_used", 32'(bus.instr_used), 32'h3);
        check("prefix_alu_sel", 32'(bus.alu_sel), 32'h3);
        check("prefix_mem_sel", 32'(bus.mem_sel), 32'h0);
        tick();
        check("prefix_cred", 32'(dut.alu_cred_q), 32'd0);

        // Five stalled cycles: slot 0 ALU with no credit.
        set_slots(A, M, M, M, 4'b1111);
        #1;
        check("stall_used", 32'(bus.instr_used), 32'h0);
        for (int i = 0; i < 5; i++) tick();
        check("stall_count", 32'(stall_cycles), exp_stall);

        // Four MEM accepted while ALU frees 4.
        set_slots(M, M2, M, M2, 4'b1111);
        alu_free = 3'd4;
        #1;
        check("mem4_used", 32'(bus.instr_used), 32'hF);
        check("mem4_mem_sel", 32'(bus.mem_sel), 32'hF);
        tick();
        alu_free = 3'd0;
        check("mem4_mem_cred", 32'(dut.mem_cred_q), 32'd0);
        check("mem4_alu_cred", 32'(dut.alu_cred_q), 32'd4);

        // Same-cycle free does not grant credit until the next cycle.
        set_slots(M, M, A, A, 4'b0011);
        mem_free = 3'd2;
        #1;
        check("memfree_used", 32'(bus.instr_used), 32'h0);
        tick();
        mem_free = 3'd0;
        check("memfree_cred", 32'(dut.mem_cred_q), 32'd2);
        #1;
        check("memfree_next_used", 32'(bus.instr_used), 32'h3);
        check("memfree_next_sel", 32'(bus.mem_sel), 32'h3);
        tick();
        check("memfree_after", 32'(dut.mem_cred_q), 32'd0);

        // Refill and clamp at depth.
        bus.instr_valid = 4'b0000;
        alu_free = 3'd4;
        mem_free = 3'd4;
        tick();
        check("refill_alu", 32'(dut.alu_cred_q), 32'd8);
        check("refill_mem", 32'(dut.mem_cred_q), 32'd4);
        tick();
        check("clamp_alu", 32'(dut.alu_cred_q), 32'd8);
        check("clamp_mem", 32'(dut.mem_cred_q), 32'd4);
        alu_free = 3'd0;
        mem_free = 3'd0;

        // TERM in slot 1.
        set_slots(A, T, A, A, 4'b1111);
        #1;
        check("term_used", 32'(bus.instr_used), 32'h3);
        check("term_term_sel", 32'(bus.term_sel), 32'h2);
        check("term_alu_sel", 32'(bus.alu_sel), 32'h1);
        tick();
        check("term_state", 32'(dut.state_q), 32'(StDrain));
        check("term_running", 32'(running), 32'h0);
        check("term_alu_cred", 32'(dut.alu_cred_q), 32'd7);
        #1;
        check("drain_used", 32'(bus.instr_used), 32'h0);

        // Last ALU entry freed: DRAIN -> IDLE, one-cycle term_done.
        alu_free = 3'd1;
        tick();
        alu_free = 3'd0;
        check("idle_state", 32'(dut.state_q), 32'(StIdle));
        check("idle_term_done", 32'(term_done), 32'h1);
        tick();
        check("idle_term_done_low", 32'(term_done), 32'h0);
        check("idle_running", 32'(running), 32'h0);
        check("idle_used", 32'(bus.instr_used), 32'h0);
        wakeup = 1'b1;
        tick();
        wakeup = 1'b0;
        check("wake_running", 32'(running), 32'h1);

        // Reset in the middle of a drain.
        set_slots(A, T, M, M, 4'b1111);
        tick();
        bus.instr_valid = 4'b0000;
        check("drain2_state", 32'(dut.state_q), 32'(StDrain));
        tick();
        check("drain2_hold", 32'(dut.state_q), 32'(StDrain));
        rst = 1'b0;
        tick();
        check("rst2_running", 32'(running), 32'h1);
        check("rst2_alu_cred", 32'(dut.alu_cred_q), 32'd8);
        check("rst2_mem_cred", 32'(dut.mem_cred_q), 32'd4);
        check("rst2_term_done", 32'(term_done), 32'h0);
        check("rst2_stall", 32'(stall_cycles), 32'h0);
        set_slots(A, A, A, A, 4'b1111);
        #1;
        check("rst2_used", 32'(bus.instr_used), 32'h0);
        rst = 1'b1;
        bus.instr_valid = 4'b0000;
        tick();
        check("rst2_no_pulse", 32'(term_done), 32'h0);
        check("rst2_still_run", 32'(running), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
